// File: rtl/simple_bfm_arb_pkg.sv
// Shared types for the simple-BFM round-robin arbiter.
// Optional timeout abort is enabled by defining SIMPLE_BFM_ARB_TIMEOUT_EN.
package simple_bfm_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDrain
  } state_e;

  // Index width that stays at least one bit wide for degenerate counts.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/simple_bfm_rr_picker.sv
// Combinational round-robin pick: first set request after last_i, wrapping modulo N_REQ.
module simple_bfm_rr_picker
  import simple_bfm_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IdxW  = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IdxW-1:0]  last_i,
  output logic             valid_o,
  output logic [IdxW-1:0]  idx_o
);

  always_comb begin
    int unsigned     cand;
    logic [IdxW-1:0] cand_idx;
    logic            found;
    cand     = 0;
    cand_idx = '0;
    found    = 1'b0;
    idx_o    = '0;
    // Scan from last_i+1 so the previous winner has the lowest priority.
    for (int unsigned off = 1; off <= N_REQ; off++) begin
      cand     = (32'(last_i) + off) % N_REQ;
      cand_idx = IdxW'(cand);
      if (!found && req_i[cand_idx]) begin
        found = 1'b1;
        idx_o = cand_idx;
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/simple_bfm_arbiter.sv
// Round-robin arbiter sharing one req/data/ack target among N_REQ requesters.
// Define SIMPLE_BFM_ARB_TIMEOUT_EN to abort stuck transactions after TIMEOUT_CYCLES.
module simple_bfm_arbiter
  import simple_bfm_arb_pkg::*;
#(
  parameter int unsigned N_REQ          = 4,
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  localparam int unsigned IdxW          = idx_w(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_i,
  input  logic [N_REQ*DATA_W-1:0] data_i,
  output logic [N_REQ-1:0]        ack_o,
  output logic                    req_o,
  output logic [DATA_W-1:0]       data_o,
  input  logic                    ack_i,
  output logic                    busy_o,
  output logic [IdxW-1:0]         gnt_idx_o,
  output logic                    err_o
);

  if (N_REQ < 2 || N_REQ > 16 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("simple_bfm_arbiter: N_REQ must be 2..16 and TIMEOUT_CYCLES at least 1");
  end

  state_e              state_q, state_d;
  logic [IdxW-1:0]     gnt_q, gnt_d;
  logic [IdxW-1:0]     last_q, last_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                req_q, req_d;
  logic [N_REQ-1:0]    ack_q, ack_d;
  logic                done;
  logic                pick_valid;
  logic [IdxW-1:0]     pick_idx;
  logic [DATA_W-1:0]   pick_data;

`ifdef SIMPLE_BFM_ARB_TIMEOUT_EN
  localparam int unsigned CntW = idx_w(TIMEOUT_CYCLES);
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
`endif

  simple_bfm_rr_picker #(
    .N_REQ(N_REQ),
    .IdxW (IdxW)
  ) u_picker (
    .req_i  (req_i),
    .last_i (last_q),
    .valid_o(pick_valid),
    .idx_o  (pick_idx)
  );

  always_comb begin
    pick_data = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (pick_idx == IdxW'(i)) pick_data = data_i[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    data_d  = data_q;
    req_d   = req_q;
    ack_d   = '0;
    done    = 1'b0;
`ifdef SIMPLE_BFM_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          gnt_d   = pick_idx;
          data_d  = pick_data;
          req_d   = 1'b1;
          state_d = StBusy;
`ifdef SIMPLE_BFM_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      StBusy: begin
        done = ack_i;
`ifdef SIMPLE_BFM_ARB_TIMEOUT_EN
        // A real ack on the final cycle takes precedence over the abort.
        if (!ack_i) begin
          if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
            done  = 1'b1;
            err_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
`endif
        if (done) begin
          req_d   = 1'b0;
          ack_d   = N_REQ'(1) << gnt_q;
          last_d  = gnt_q;
          state_d = StDrain;
        end
      end
      StDrain: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      last_q  <= IdxW'(N_REQ - 1);
      data_q  <= '0;
      req_q   <= 1'b0;
      ack_q   <= '0;
`ifdef SIMPLE_BFM_ARB_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      data_q  <= data_d;
      req_q   <= req_d;
      ack_q   <= ack_d;
`ifdef SIMPLE_BFM_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign ack_o     = ack_q;
  assign req_o     = req_q;
  assign data_o    = data_q;
  assign busy_o    = (state_q != StIdle);
  assign gnt_idx_o = gnt_q;
`ifdef SIMPLE_BFM_ARB_TIMEOUT_EN
  assign err_o     = err_q;
`else
  assign err_o     = 1'b0;
`endif

endmodule
